// File: rtl/dff_ram_8x72_arbiter_if.sv
// Request/response handshake between one client engine and the dff_ram_8x72 arbiter.
// The client drives the master side and the arbiter takes the slave side.
interface dff_ram_8x72_arbiter_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 72
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dff_ram_8x72_arbiter.sv
// Round-robin arbiter/sequencer letting two requesters share a single-port 8x72 RAM.
// One operation in flight: IDLE (grant) -> ACCESS (RAM cycle) -> RESP (hold until consumed).
module dff_ram_8x72_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 72
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dff_ram_8x72_arbiter_if.slave a_if,
  dff_ram_8x72_arbiter_if.slave b_if,
  output logic                  ram_wr_n,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  busy,
  output logic                  grant_b
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q;
  logic              en_q;
  logic              prio_b_q;
  logic              grant_b_q;
  logic              we_q;
  logic              ram_wr_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              a_rsp_valid_q;
  logic              b_rsp_valid_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic              a_sel;
  logic              b_sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rsp_done;

  // en_q keeps req_ready low while reset is held, without using rst_n as data.
  always_comb begin
    a_sel = 1'b0;
    b_sel = 1'b0;
    if (en_q && state_q == IDLE) begin
      if (a_if.req_valid && (!b_if.req_valid || !prio_b_q)) begin
        a_sel = 1'b1;
      end else if (b_if.req_valid) begin
        b_sel = 1'b1;
      end
    end
  end

  assign sel_we    = b_sel ? b_if.req_we    : a_if.req_we;
  assign sel_addr  = b_sel ? b_if.req_addr  : a_if.req_addr;
  assign sel_wdata = b_sel ? b_if.req_wdata : a_if.req_wdata;
  assign rsp_done  = grant_b_q ? b_if.rsp_ready : a_if.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      prio_b_q      <= 1'b0;
      grant_b_q     <= 1'b0;
      we_q          <= 1'b0;
      ram_wr_n_q    <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (a_sel || b_sel) begin
            grant_b_q  <= b_sel;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            ram_wr_n_q <= ~sel_we;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          ram_wr_n_q <= 1'b1;
          if (grant_b_q) begin
            b_rdata_q     <= we_q ? '0 : ram_rdata;
            b_rsp_valid_q <= 1'b1;
          end else begin
            a_rdata_q     <= we_q ? '0 : ram_rdata;
            a_rsp_valid_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            prio_b_q      <= ~grant_b_q;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_if.req_ready = a_sel;
  assign b_if.req_ready = b_sel;
  assign a_if.rsp_valid = a_rsp_valid_q;
  assign b_if.rsp_valid = b_rsp_valid_q;
  assign a_if.rsp_rdata = a_rdata_q;
  assign b_if.rsp_rdata = b_rdata_q;
  assign ram_wr_n       = ram_wr_n_q;
  assign ram_address    = addr_q;
  assign ram_wdata      = wdata_q;
  assign busy           = (state_q != IDLE);
  assign grant_b        = grant_b_q;

endmodule

// File: tb/tb_dff_ram_8x72_arbiter.sv
// Bench for dff_ram_8x72_arbiter: RAM model plus a transaction-level memory/round-robin reference.
module tb_dff_ram_8x72_arbiter;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 72;
  localparam int unsigned DEPTH  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dff_ram_8x72_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
  dff_ram_8x72_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();

  logic              ram_wr_n;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic              grant_b;
  logic [DATA_W-1:0] mem [DEPTH];

  dff_ram_8x72_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .a_if(a_if), .b_if(b_if),
    .ram_wr_n(ram_wr_n), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .grant_b(grant_b)
  );

  always @(posedge clk) if (ram_wr_n === 1'b0) mem[ram_address] <= ram_wdata;
  assign ram_rdata = mem[ram_address];

  logic [DATA_W-1:0] exp_mem [DEPTH];
  bit                exp_prio_b;
  int                n_checks = 0;
  int                n_fail   = 0;

  function automatic logic [DATA_W-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  function automatic bit req_rdy(input bit is_b);
    return is_b ? b_if.req_ready : a_if.req_ready;
  endfunction
  function automatic bit rsp_vld(input bit is_b);
    return is_b ? b_if.rsp_valid : a_if.rsp_valid;
  endfunction
  function automatic logic [DATA_W-1:0] rsp_dat(input bit is_b);
    return is_b ? b_if.rsp_rdata : a_if.rsp_rdata;
  endfunction

  // Reference: with both waiting the priority holder wins, otherwise whoever waits.
  function automatic bit model_pick_b(input bit a_wait, input bit b_wait);
    return (a_wait && b_wait) ? exp_prio_b : b_wait;
  endfunction

  task automatic model_op(input bit is_b, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] exp_rd);
    exp_rd = we ? '0 : exp_mem[addr];
    if (we) exp_mem[addr] = d;
    exp_prio_b = !is_b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit is_b, input bit v, input bit we,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
    if (is_b) begin
      b_if.req_valid = v; b_if.req_we = we; b_if.req_addr = addr; b_if.req_wdata = d;
    end else begin
      a_if.req_valid = v; a_if.req_we = we; a_if.req_addr = addr; a_if.req_wdata = d;
    end
  endtask

  task automatic quiet();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    a_if.rsp_ready = 1'b1;
    b_if.rsp_ready = 1'b1;
  endtask

  // Lone-requester transaction; reports what it observed, callers judge it.
  task automatic run_op(input bit is_b, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd,
                        output int lat, output int wrc, output bit oth, output bit ok);
    int n;
    rd = '0; lat = 0; wrc = 0; oth = 1'b0; ok = 1'b0;
    drive(is_b, 1'b1, we, addr, d);
    #1;
    n = 0;
    while (!req_rdy(is_b) && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      drive(is_b, 1'b0, 1'b0, '0, '0);
      return;
    end
    tick();
    drive(is_b, 1'b0, 1'b0, '0, '0);
    for (int s = 1; s <= 10; s++) begin
      if (ram_wr_n === 1'b0) wrc++;
      if (rsp_vld(!is_b) !== 1'b0) oth = 1'b1;
      if (rsp_vld(is_b) === 1'b1) begin
        lat = s;
        rd  = rsp_dat(is_b);
        break;
      end
      tick();
    end
    ok = (lat != 0);
    if (ok) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), rand_word());
      drive(1'b1, 1'($urandom), 1'($urandom), 3'($urandom), rand_word());
      a_if.rsp_ready = 1'($urandom);
      b_if.rsp_ready = 1'($urandom);
      tick();
      n_checks++;
      if ({a_if.req_ready, b_if.req_ready, a_if.rsp_valid, b_if.rsp_valid, busy, grant_b} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl: got %b want 000000", {a_if.req_ready, b_if.req_ready, a_if.rsp_valid, b_if.rsp_valid, busy, grant_b});
      end
      n_checks++;
      if (ram_wr_n !== 1'b1) begin n_fail++; $display("FAIL reset_wr_n: got %b want 1", ram_wr_n); end
      n_checks++;
      if (ram_address !== '0 || ram_wdata !== '0) begin
        n_fail++; $display("FAIL reset_ram_bus: got addr %0d data %h want 0/0", ram_address, ram_wdata);
      end
      n_checks++;
      if (a_if.rsp_rdata !== '0 || b_if.rsp_rdata !== '0) begin
        n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", a_if.rsp_rdata, b_if.rsp_rdata);
      end
    end
    quiet();
    rst_n = 1'b1;
    exp_prio_b = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] rd, exp;
    logic [DATA_W-1:0] pat;
    int lat, wrc;
    bit oth, ok;
    pat = 72'hA5A5_0000_0000_0000_01;
    run_op(1'b0, 1'b1, 3'd3, pat, rd, lat, wrc, oth, ok);
    model_op(1'b0, 1'b1, 3'd3, pat, exp);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_wr_timeout: got %b want 1", ok); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL single_wr_latency: got %0d want 2", lat); end
    n_checks++; if (wrc != 1) begin n_fail++; $display("FAIL single_wr_pulse: got %0d want 1", wrc); end
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL single_wr_ack: got %h want %h", rd, exp); end
    n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL single_wr_other_rsp: got %b want 0", oth); end
    run_op(1'b1, 1'b0, 3'd3, '0, rd, lat, wrc, oth, ok);
    model_op(1'b1, 1'b0, 3'd3, '0, exp);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL single_rd_latency: got %0d want 2", lat); end
    n_checks++; if (wrc != 0) begin n_fail++; $display("FAIL single_rd_pulse: got %0d want 0", wrc); end
    n_checks++; if (rd !== pat) begin n_fail++; $display("FAIL single_rd_data: got %h want %h", rd, pat); end
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL single_rd_model: got %h want %h", rd, exp); end
    n_checks++; if (grant_b !== 1'b1) begin n_fail++; $display("FAIL single_grant_b: got %b want 1", grant_b); end
  endtask

  task automatic test_sweep();
    logic [DATA_W-1:0] rd, exp;
    int lat, wrc;
    bit oth, ok;
    for (int i = 0; i < 8; i++) begin
      run_op(1'(i % 2), 1'b1, 3'(i), DATA_W'(i + 1), rd, lat, wrc, oth, ok);
      model_op(1'(i % 2), 1'b1, 3'(i), DATA_W'(i + 1), exp);
      n_checks++;
      if (!ok || rd !== '0 || wrc != 1) begin
        n_fail++; $display("FAIL sweep_wr[%0d]: got ok %b ack %h pulses %0d want 1/0/1", i, ok, rd, wrc);
      end
    end
    for (int i = 0; i < 8; i++) begin
      run_op(1'(i % 2), 1'b0, 3'(i), '0, rd, lat, wrc, oth, ok);
      model_op(1'(i % 2), 1'b0, 3'(i), '0, exp);
      n_checks++;
      if (rd !== DATA_W'(i + 1)) begin
        n_fail++; $display("FAIL sweep_rd[%0d]: got %h want %h", i, rd, DATA_W'(i + 1));
      end
    end
  endtask

  task automatic test_contention();
    bit                pw [2];
    logic [ADDR_W-1:0] pa [2];
    logic [DATA_W-1:0] pd [2];
    logic [DATA_W-1:0] exp;
    bit                who;
    int                n;
    rst_n = 1'b0;
    quiet();
    for (int r = 0; r < 2; r++) begin
      pw[r] = 1'($urandom); pa[r] = 3'($urandom); pd[r] = rand_word();
      drive(1'(r), 1'b1, pw[r], pa[r], pd[r]);
    end
    tick();
    rst_n = 1'b1;
    exp_prio_b = 1'b0;
    for (int op = 0; op < 6; op++) begin
      n = 0;
      while (!a_if.req_ready && !b_if.req_ready && n < 20) begin tick(); n++; end
      who = b_if.req_ready;
      n_checks++;
      if (n >= 20 || (a_if.req_ready && b_if.req_ready)) begin
        n_fail++; $display("FAIL cont_ready[%0d]: got a %b b %b want exactly one", op, a_if.req_ready, b_if.req_ready);
      end
      n_checks++;
      if (who !== model_pick_b(1'b1, 1'b1) || who !== 1'(op % 2)) begin
        n_fail++; $display("FAIL cont_order[%0d]: got b=%b want b=%b", op, who, 1'(op % 2));
      end
      tick();
      n_checks++;
      if (grant_b !== who) begin n_fail++; $display("FAIL cont_grant_b[%0d]: got %b want %b", op, grant_b, who); end
      model_op(who, pw[who], pa[who], pd[who], exp);
      pw[who] = 1'($urandom); pa[who] = 3'($urandom); pd[who] = rand_word();
      drive(who, 1'b1, pw[who], pa[who], pd[who]);
      n = 0;
      while (!rsp_vld(who) && n < 10) begin tick(); n++; end
      n_checks++;
      if (rsp_vld(who) !== 1'b1 || rsp_dat(who) !== exp || rsp_vld(!who) !== 1'b0) begin
        n_fail++; $display("FAIL cont_rsp[%0d]: got valid %b data %h other %b want 1 %h 0", op, rsp_vld(who), rsp_dat(who), rsp_vld(!who), exp);
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] rd, exp, d;
    logic [ADDR_W-1:0] addr;
    int lat, wrc;
    bit oth, ok, is_b, we;
    for (int k = 0; k < 20; k++) begin
      is_b = 1'($urandom); we = 1'($urandom); addr = 3'($urandom); d = rand_word();
      run_op(is_b, we, addr, d, rd, lat, wrc, oth, ok);
      model_op(is_b, we, addr, d, exp);
      n_checks++;
      if (!ok || lat != 2 || rd !== exp || oth !== 1'b0 || wrc != int'(we) || grant_b !== is_b) begin
        n_fail++;
        $display("FAIL random[%0d]: got ok %b lat %0d data %h oth %b pulses %0d grant_b %b want 1 2 %h 0 %0d %b",
                 k, ok, lat, rd, oth, wrc, grant_b, exp, int'(we), is_b);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] exp, bexp;
    logic [ADDR_W-1:0] addr, baddr;
    int n;
    quiet();
    a_if.rsp_ready = 1'b0;
    addr = 3'($urandom);
    drive(1'b0, 1'b1, 1'b0, addr, '0);
    #1;
    n = 0;
    while (!a_if.req_ready && n < 20) begin tick(); n++; end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    model_op(1'b0, 1'b0, addr, '0, exp);
    baddr = 3'($urandom);
    drive(1'b1, 1'b1, 1'b0, baddr, '0);
    n = 0;
    while (!a_if.rsp_valid && n < 10) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (a_if.rsp_valid !== 1'b1 || a_if.rsp_rdata !== exp || b_if.req_ready !== 1'b0 ||
          ram_wr_n !== 1'b1 || b_if.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got a_valid %b data %h b_ready %b wr_n %b b_valid %b want 1 %h 0 1 0",
                 c, a_if.rsp_valid, a_if.rsp_rdata, b_if.req_ready, ram_wr_n, b_if.rsp_valid, exp);
      end
      tick();
    end
    a_if.rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (a_if.rsp_valid !== 1'b0 || b_if.req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got a_valid %b b_ready %b busy %b want 0 1 0", a_if.rsp_valid, b_if.req_ready, busy);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    model_op(1'b1, 1'b0, baddr, '0, bexp);
    n_checks++;
    if (grant_b !== 1'b1) begin n_fail++; $display("FAIL bp_grant_b: got %b want 1", grant_b); end
    n = 0;
    while (!b_if.rsp_valid && n < 10) begin tick(); n++; end
    n_checks++;
    if (b_if.rsp_valid !== 1'b1 || b_if.rsp_rdata !== bexp) begin
      n_fail++; $display("FAIL bp_b_rsp: got valid %b data %h want 1 %h", b_if.rsp_valid, b_if.rsp_rdata, bexp);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    logic [DATA_W-1:0] rd, exp, d;
    int lat, wrc, n;
    bit oth, ok;
    quiet();
    drive(1'b0, 1'b1, 1'b1, 3'd5, ~exp_mem[5]);
    #1;
    n = 0;
    while (!a_if.req_ready && n < 20) begin tick(); n++; end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (ram_wr_n !== 1'b0) begin n_fail++; $display("FAIL midop_access_wr_n: got %b want 0", ram_wr_n); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_wr_n !== 1'b1 || busy !== 1'b0 || a_if.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_async: got wr_n %b busy %b a_valid %b want 1 0 0", ram_wr_n, busy, a_if.rsp_valid);
    end
    tick();
    rst_n = 1'b1;
    exp_prio_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (a_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midop_no_rsp[%0d]: got %b want 0", c, a_if.rsp_valid); end
    end
    d = rand_word();
    run_op(1'b1, 1'b1, 3'd5, d, rd, lat, wrc, oth, ok);
    model_op(1'b1, 1'b1, 3'd5, d, exp);
    n_checks++;
    if (!ok || rd !== exp || wrc != 1 || grant_b !== 1'b1) begin
      n_fail++; $display("FAIL midop_b_wr: got ok %b ack %h pulses %0d grant_b %b want 1 %h 1 1", ok, rd, wrc, grant_b, exp);
    end
    run_op(1'b1, 1'b0, 3'd5, '0, rd, lat, wrc, oth, ok);
    model_op(1'b1, 1'b0, 3'd5, '0, exp);
    n_checks++;
    if (!ok || rd !== d || lat != 2) begin
      n_fail++; $display("FAIL midop_b_rd: got ok %b data %h lat %0d want 1 %h 2", ok, rd, lat, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
    exp_prio_b = 1'b0;
    quiet();
    #2;
    test_reset();
    test_single();
    test_sweep();
    test_contention();
    test_random();
    test_backpressure();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
